// File: rtl/mcu_stage_sequencer.sv
// EDSAC main-control stage sequencer.
// Free-runs the digit / minor-cycle timebase and steps each order through
// fetch (s1), execute (s2) and the Sequence Control Tank increment, waiting on
// the CCU end pulses between stages and guarding every wait with a timeout.
module mcu_stage_sequencer #(
   parameter int DIGITS     = 36,
   parameter int EP_TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop_req,
   input  logic       single_step,
   input  logic       ep_any,
   input  logic       stop_one_b,
   output logic [5:0] digit,
   output logic       minor_odd,
   output logic       ev_d0,
   output logic       odd_d0,
   output logic       odd_d35,
   output logic       s1,
   output logic       s2,
   output logic       sct_inc,
   output logic       ep_done,
   output logic       running,
   output logic       fault
);

   localparam int                 TIMER_W     = $clog2(EP_TIMEOUT + 1);
   localparam logic [5:0]         DIGIT_LAST  = 6'(DIGITS - 1);
   localparam logic [TIMER_W-1:0] TIMER_MAX   = '1;
   localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(EP_TIMEOUT);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH_ARM,
      ST_FETCH_WAIT,
      ST_EXEC_ARM,
      ST_EXEC_WAIT,
      ST_INC,
      ST_HALTED
   } state_t;

   state_t               state_q, state_d;
   logic [5:0]           digit_q, digit_d;
   logic                 minor_odd_q, minor_odd_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [TIMER_W-1:0]   timer_step;
   logic                 skip_inc_q, skip_inc_d;
   logic                 stop_pend_q, stop_pend_d;
   logic                 fault_q, fault_d;
   logic                 ep_done_q, ep_done_d;
   logic                 minor_evt;
   logic                 timeout_hit;

   // Timebase next value: digit wraps at DIGITS-1 and flips the minor-cycle parity.
   always_comb begin
      digit_d     = digit_q + 6'd1;
      minor_odd_d = minor_odd_q;
      if (digit_q == DIGIT_LAST) begin
         digit_d     = 6'd0;
         minor_odd_d = ~minor_odd_q;
      end
   end

   // Timebase registers; run in every state, independent of the order cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_q     <= 6'd0;
         minor_odd_q <= 1'b0;
      end else begin
         digit_q     <= digit_d;
         minor_odd_q <= minor_odd_d;
      end
   end

   // Timing decodes taken straight from the registered counter.
   assign digit     = digit_q;
   assign minor_odd = minor_odd_q;
   assign ev_d0     = (digit_q == 6'd0) && !minor_odd_q;
   assign odd_d0    = (digit_q == 6'd0) &&  minor_odd_q;
   assign odd_d35   = (digit_q == DIGIT_LAST) && minor_odd_q;

   // A minor cycle begins at every digit 0; the wait timer counts these, saturating.
   assign minor_evt   = ev_d0 || odd_d0;
   assign timer_step  = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
   assign timeout_hit = minor_evt && (timer_step >= TIMER_LIMIT);

   // Next-state and stage-stimulus decode for the order cycle.
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      skip_inc_d  = skip_inc_q;
      stop_pend_d = stop_pend_q;
      fault_d     = fault_q;
      ep_done_d   = 1'b0;
      s1          = 1'b0;
      s2          = 1'b0;
      sct_inc     = 1'b0;

      // A stop request is only remembered while an order is in progress.
      if (running && stop_req) begin
         stop_pend_d = 1'b1;
      end

      case (state_q)
         ST_IDLE, ST_HALTED: begin
            if (start) begin
               state_d     = ST_FETCH_ARM;
               fault_d     = 1'b0;
               stop_pend_d = 1'b0;
            end
         end
         ST_FETCH_ARM: begin
            if (ev_d0) begin
               s1         = 1'b1;
               skip_inc_d = 1'b0;
               timer_d    = '0;
               state_d    = ST_FETCH_WAIT;
            end
         end
         ST_FETCH_WAIT: begin
            // An end pulse arriving on the timeout cycle still wins.
            if (ep_any) begin
               ep_done_d = 1'b1;
               state_d   = ST_EXEC_ARM;
            end else if (timeout_hit) begin
               fault_d     = 1'b1;
               stop_pend_d = 1'b0;
               state_d     = ST_HALTED;
            end else if (minor_evt) begin
               timer_d = timer_step;
            end
         end
         ST_EXEC_ARM: begin
            if (ev_d0) begin
               s2      = 1'b1;
               timer_d = '0;
               state_d = ST_EXEC_WAIT;
            end
         end
         ST_EXEC_WAIT: begin
            // Transfer orders flag themselves at any point while executing.
            if (stop_one_b) begin
               skip_inc_d = 1'b1;
            end
            if (ep_any) begin
               ep_done_d = 1'b1;
               state_d   = ST_INC;
            end else if (timeout_hit) begin
               fault_d     = 1'b1;
               stop_pend_d = 1'b0;
               state_d     = ST_HALTED;
            end else if (minor_evt) begin
               timer_d = timer_step;
            end
         end
         ST_INC: begin
            if (odd_d0) begin
               sct_inc = !skip_inc_q;
               if (stop_pend_q || stop_req || single_step) begin
                  stop_pend_d = 1'b0;
                  state_d     = ST_HALTED;
               end else begin
                  state_d = ST_FETCH_ARM;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Order-cycle control registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         timer_q     <= '0;
         skip_inc_q  <= 1'b0;
         stop_pend_q <= 1'b0;
         fault_q     <= 1'b0;
         ep_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         skip_inc_q  <= skip_inc_d;
         stop_pend_q <= stop_pend_d;
         fault_q     <= fault_d;
         ep_done_q   <= ep_done_d;
      end
   end

   assign running = (state_q == ST_FETCH_ARM)  || (state_q == ST_FETCH_WAIT) ||
                    (state_q == ST_EXEC_ARM)   || (state_q == ST_EXEC_WAIT)  ||
                    (state_q == ST_INC);
   assign ep_done = ep_done_q;
   assign fault   = fault_q;

endmodule

// File: tb/tb_mcu_stage_sequencer.sv
// Directed bench for mcu_stage_sequencer: cycle-scheduled stimulus with
// hand-computed pulse positions (DIGITS=36, EP_TIMEOUT=4).
module tb_mcu_stage_sequencer;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       stop_req;
   logic       single_step;
   logic       ep_any;
   logic       stop_one_b;
   logic [5:0] digit;
   logic       minor_odd;
   logic       ev_d0;
   logic       odd_d0;
   logic       odd_d35;
   logic       s1;
   logic       s2;
   logic       sct_inc;
   logic       ep_done;
   logic       running;
   logic       fault;

   int checks;
   int errors;
   int cyc;
   logic mon_clr;

   int s1_cnt, s2_cnt, sct_cnt, epd_cnt;
   int s1_at [8];
   int s2_at [8];
   int sct_at [8];
   int epd_at [8];

   mcu_stage_sequencer #(
      .DIGITS     (36),
      .EP_TIMEOUT (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .stop_req    (stop_req),
      .single_step (single_step),
      .ep_any      (ep_any),
      .stop_one_b  (stop_one_b),
      .digit       (digit),
      .minor_odd   (minor_odd),
      .ev_d0       (ev_d0),
      .odd_d0      (odd_d0),
      .odd_d35     (odd_d35),
      .s1          (s1),
      .s2          (s2),
      .sct_inc     (sct_inc),
      .ep_done     (ep_done),
      .running     (running),
      .fault       (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record the cycle number of every stage pulse, sampled mid-cycle.
   always @(negedge clk) begin
      if (mon_clr) begin
         s1_cnt = 0; s2_cnt = 0; sct_cnt = 0; epd_cnt = 0;
      end else begin
         if (s1 === 1'b1) begin
            if (s1_cnt < 8) s1_at[s1_cnt] = cyc;
            s1_cnt++;
         end
         if (s2 === 1'b1) begin
            if (s2_cnt < 8) s2_at[s2_cnt] = cyc;
            s2_cnt++;
         end
         if (sct_inc === 1'b1) begin
            if (sct_cnt < 8) sct_at[sct_cnt] = cyc;
            sct_cnt++;
         end
         if (ep_done === 1'b1) begin
            if (epd_cnt < 8) epd_at[epd_cnt] = cyc;
            epd_cnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic tick_to(input int c);
      while (cyc < c) tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0; mon_clr = 1'b1;
      start = 1'b0; stop_req = 1'b0; single_step = 1'b0;
      ep_any = 1'b0; stop_one_b = 1'b0;
      tick();
      tick();
      mon_clr = 1'b0;
      rst_n = 1'b1;
      cyc = 0;
   endtask

   task automatic pulse_start(input int c);
      tick_to(c);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_stop(input int c);
      tick_to(c);
      stop_req = 1'b1;
      tick();
      stop_req = 1'b0;
   endtask

   task automatic pulse_ep(input int c, input logic with_stop_one);
      tick_to(c);
      ep_any = 1'b1;
      stop_one_b = with_stop_one;
      tick();
      ep_any = 1'b0;
      stop_one_b = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mon_clr = 1'b1;
      start = 1'b0; stop_req = 1'b0; single_step = 1'b0;
      ep_any = 1'b0; stop_one_b = 1'b0;
      cyc = 0;
      tick();
      tick();
      checks++;
      if ({digit, minor_odd, s1, s2, sct_inc, ep_done, running, fault} !== 13'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 0",
                  {digit, minor_odd, s1, s2, sct_inc, ep_done, running, fault});
      end
      mon_clr = 1'b0;
      rst_n = 1'b1;
      cyc = 0;
      checks++;
      if (ev_d0 !== 1'b1 || digit !== 6'd0 || running !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: ev_d0=%b digit=%0d running=%b expected 1/0/0",
                  ev_d0, digit, running);
      end
   endtask

   task automatic test_timebase();
      for (int c = 0; c < 74; c++) begin
         tick_to(c);
         checks++;
         if (digit !== 6'(c % 36) || minor_odd !== 1'((c / 36) % 2)) begin
            errors++;
            $display("FAIL timebase_cnt c=%0d: got digit=%0d odd=%b expected %0d/%0d",
                     c, digit, minor_odd, c % 36, (c / 36) % 2);
         end
         checks++;
         if (ev_d0 !== 1'(c == 0 || c == 72) || odd_d0 !== 1'(c == 36) || odd_d35 !== 1'(c == 71)) begin
            errors++;
            $display("FAIL timebase_dec c=%0d: got ev_d0=%b odd_d0=%b odd_d35=%b", c, ev_d0, odd_d0, odd_d35);
         end
      end
      checks++;
      if (s1_cnt !== 0 || running !== 1'b0) begin
         errors++;
         $display("FAIL timebase_idle: got s1_cnt=%0d running=%b expected 0/0", s1_cnt, running);
      end
   endtask

   task automatic test_order_cycle();
      do_reset();
      pulse_start(5);
      pulse_ep(82, 1'b0);
      tick_to(100);
      checks++;
      if (running !== 1'b1) begin
         errors++;
         $display("FAIL order_running: got %b expected 1", running);
      end
      pulse_ep(100, 1'b0);          // EXEC_ARM: must be ignored
      pulse_start(120);             // running: must be ignored
      pulse_ep(154, 1'b0);
      tick_to(217);
      checks++;
      if (s1_cnt !== 2 || s1_at[0] !== 72 || s1_at[1] !== 216) begin
         errors++;
         $display("FAIL order_s1: got cnt=%0d at %0d,%0d expected 2 at 72,216", s1_cnt, s1_at[0], s1_at[1]);
      end
      checks++;
      if (epd_cnt !== 2 || epd_at[0] !== 83 || epd_at[1] !== 155) begin
         errors++;
         $display("FAIL order_ep_done: got cnt=%0d at %0d,%0d expected 2 at 83,155", epd_cnt, epd_at[0], epd_at[1]);
      end
      checks++;
      if (s2_cnt !== 1 || s2_at[0] !== 144) begin
         errors++;
         $display("FAIL order_s2: got cnt=%0d at %0d expected 1 at 144", s2_cnt, s2_at[0]);
      end
      checks++;
      if (sct_cnt !== 1 || sct_at[0] !== 180) begin
         errors++;
         $display("FAIL order_sct_inc: got cnt=%0d at %0d expected 1 at 180", sct_cnt, sct_at[0]);
      end
   endtask

   task automatic test_stop_one_b();
      do_reset();
      pulse_start(5);
      pulse_ep(82, 1'b0);
      pulse_ep(154, 1'b1);
      tick_to(217);
      checks++;
      if (sct_cnt !== 0 || s1_cnt !== 2) begin
         errors++;
         $display("FAIL skip_inc: got sct_cnt=%0d s1_cnt=%0d expected 0/2", sct_cnt, s1_cnt);
      end
      pulse_ep(226, 1'b0);
      pulse_ep(298, 1'b0);
      tick_to(325);
      checks++;
      if (sct_cnt !== 1 || sct_at[0] !== 324 || s2_at[1] !== 288 || epd_cnt !== 4) begin
         errors++;
         $display("FAIL skip_next_order: got sct_cnt=%0d at %0d s2=%0d epd=%0d expected 1 at 324, 288, 4",
                  sct_cnt, sct_at[0], s2_at[1], epd_cnt);
      end
   endtask

   task automatic test_single_step();
      do_reset();
      single_step = 1'b1;
      pulse_start(5);
      pulse_ep(82, 1'b0);
      pulse_ep(154, 1'b0);
      tick_to(182);
      checks++;
      if (s1_cnt !== 1 || s2_cnt !== 1 || sct_cnt !== 1 || sct_at[0] !== 180 || running !== 1'b0) begin
         errors++;
         $display("FAIL step_first: got s1=%0d s2=%0d sct=%0d at %0d running=%b expected 1/1/1 at 180/0",
                  s1_cnt, s2_cnt, sct_cnt, sct_at[0], running);
      end
      pulse_start(190);
      pulse_ep(226, 1'b0);
      pulse_ep(298, 1'b0);
      tick_to(330);
      checks++;
      if (s1_cnt !== 2 || s1_at[1] !== 216 || sct_cnt !== 2 || sct_at[1] !== 324 || running !== 1'b0) begin
         errors++;
         $display("FAIL step_second: got s1=%0d at %0d sct=%0d at %0d running=%b expected 2 at 216, 2 at 324, 0",
                  s1_cnt, s1_at[1], sct_cnt, sct_at[1], running);
      end
      tick_to(400);
      checks++;
      if (s1_cnt !== 2) begin
         errors++;
         $display("FAIL step_halted: got s1_cnt=%0d expected 2", s1_cnt);
      end
      single_step = 1'b0;
   endtask

   task automatic test_timeout();
      do_reset();
      pulse_start(5);
      pulse_ep(82, 1'b0);
      tick_to(288);
      checks++;
      if (fault !== 1'b0 || running !== 1'b1) begin
         errors++;
         $display("FAIL timeout_early: got fault=%b running=%b expected 0/1", fault, running);
      end
      tick_to(289);
      checks++;
      if (fault !== 1'b1 || running !== 1'b0 || epd_cnt !== 1 || sct_cnt !== 0) begin
         errors++;
         $display("FAIL timeout_fault: got fault=%b running=%b epd=%0d sct=%0d expected 1/0/1/0",
                  fault, running, epd_cnt, sct_cnt);
      end
      pulse_start(300);
      checks++;
      if (fault !== 1'b0 || running !== 1'b1) begin
         errors++;
         $display("FAIL timeout_clear: got fault=%b running=%b expected 0/1", fault, running);
      end
   endtask

   task automatic test_reset_and_stop();
      do_reset();
      pulse_start(5);
      pulse_ep(82, 1'b0);
      tick_to(150);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({digit, minor_odd, s1, s2, sct_inc, ep_done, running, fault} !== 13'd0) begin
         errors++;
         $display("FAIL midrun_reset: got %b expected 0",
                  {digit, minor_odd, s1, s2, sct_inc, ep_done, running, fault});
      end
      do_reset();
      tick_to(80);
      checks++;
      if (s1_cnt !== 0 || running !== 1'b0 || epd_cnt !== 0) begin
         errors++;
         $display("FAIL reset_quiet: got s1=%0d running=%b epd=%0d expected 0/0/0", s1_cnt, running, epd_cnt);
      end
      do_reset();
      pulse_start(5);
      pulse_stop(76);
      pulse_ep(82, 1'b0);
      pulse_ep(154, 1'b0);
      tick_to(182);
      checks++;
      if (sct_cnt !== 1 || sct_at[0] !== 180 || running !== 1'b0) begin
         errors++;
         $display("FAIL stop_completes: got sct=%0d at %0d running=%b expected 1 at 180, 0",
                  sct_cnt, sct_at[0], running);
      end
      tick_to(220);
      checks++;
      if (s1_cnt !== 1) begin
         errors++;
         $display("FAIL stop_halted: got s1_cnt=%0d expected 1", s1_cnt);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_timebase();
      test_order_cycle();
      test_stop_one_b();
      test_single_step();
      test_timeout();
      test_reset_and_stop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
